// File: rtl/varredura_tabela_pkg.sv
// Shared definitions for the truth-table sweep stage: FSM encoding and the golden table
// of the 3-input mux circuit under test.
package varredura_tabela_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } estado_e;

    localparam int unsigned N_IN_PADRAO   = 3;
    localparam int unsigned SETTLE_PADRAO = 2;

    // saida = ~(a ^ c); bit i is the expected output for abc == i.
    localparam logic [7:0] TABELA_MUX = 8'hA5;

endpackage

// File: rtl/varredura_tabela_if.sv
// Bundle between the sweep stage (master) and the circuit/observer side (slave).
interface varredura_tabela_if #(
    parameter int unsigned N_IN = 3
);
    localparam int unsigned NV = 2 ** N_IN;

    logic              start;
    logic              dut_out;
    logic [N_IN-1:0]   abc;
    logic              busy;
    logic [NV-1:0]     tabela;
    logic [N_IN:0]     erros;
    logic              done;
    logic              pass;

    modport master (
        input  start,
        input  dut_out,
        output abc,
        output busy,
        output tabela,
        output erros,
        output done,
        output pass
    );

    modport slave (
        output start,
        output dut_out,
        input  abc,
        input  busy,
        input  tabela,
        input  erros,
        input  done,
        input  pass
    );

endinterface

// File: rtl/varredura_tabela_contador_espera.sv
// Settle-delay down-counter: loaded with SETTLE-1 when a vector is driven, counts down while
// enabled and flags the last settle cycle with a terminal-count pulse.
module varredura_tabela_contador_espera #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0] CARGA = W'(SETTLE - 1);

    logic [W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == '0);

    // Load on a new vector, otherwise count down to zero and stay there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CARGA;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/varredura_tabela.sv
// Self-checking sweep stage: drives every {a,b,c} vector onto the circuit, samples its output
// after a settle delay, builds the measured truth table and compares it with a golden table.
module varredura_tabela
    import varredura_tabela_pkg::*;
#(
    parameter int unsigned             N_IN     = N_IN_PADRAO,
    parameter int unsigned             SETTLE   = SETTLE_PADRAO,
    parameter logic [(2**N_IN)-1:0]    EXPECTED = TABELA_MUX
) (
    input  logic                   clk,
    input  logic                   rst_n,
    varredura_tabela_if.master     bus
);

    localparam int unsigned NV = 2 ** N_IN;

    estado_e           r_estado;
    logic [N_IN-1:0]   r_abc;
    logic [NV-1:0]     r_tabela;
    logic [N_IN:0]     r_erros;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_aceita;
    logic              w_ultimo;
    logic              w_erro;
    logic              w_load;
    logic              w_en;
    logic              w_tc;

    // start only counts from IDLE or DONE; ignored while a sweep is running.
    assign w_aceita = ((r_estado == StIdle) || (r_estado == StDone)) && bus.start;
    assign w_ultimo = &r_abc;
    assign w_erro   = (bus.dut_out != EXPECTED[r_abc]);
    // Reload the settle delay whenever a fresh vector goes out.
    assign w_load   = w_aceita || ((r_estado == StSample) && !w_ultimo);
    assign w_en     = (r_estado == StSettle);

    varredura_tabela_contador_espera #(
        .SETTLE (SETTLE)
    ) u_contador_espera (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_en),
        .o_tc   (w_tc)
    );

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= StIdle;
            r_abc    <= '0;
            r_tabela <= '0;
            r_erros  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            unique case (r_estado)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_abc    <= '0;
                        r_tabela <= '0;
                        r_erros  <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_estado <= StSettle;
                    end
                end
                StSettle: begin
                    if (w_tc) begin
                        r_estado <= StSample;
                    end
                end
                StSample: begin
                    r_tabela[r_abc] <= bus.dut_out;
                    if (w_erro) begin
                        r_erros <= r_erros + 1'b1;
                    end
                    if (w_ultimo) begin
                        // Verdict includes the mismatch of this final sample.
                        r_pass   <= (r_erros == '0) && !w_erro;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_estado <= StDone;
                    end else begin
                        r_abc    <= r_abc + 1'b1;
                        r_estado <= StSettle;
                    end
                end
                default: r_estado <= StIdle;
            endcase
        end
    end

    assign bus.abc    = r_abc;
    assign bus.tabela = r_tabela;
    assign bus.erros  = r_erros;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.pass   = r_pass;

endmodule

// File: tb/tb_varredura_tabela.sv
// Bench for varredura_tabela: two instances (SETTLE=2 and SETTLE=1) share start/reset and a
// circuit model given as a truth table. A cycle-count model predicts every output each cycle.
`timescale 1ns/1ps
module tb_varredura_tabela;
    import varredura_tabela_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] circ_tab;
    logic       chk_en;

    int n_chk;
    int n_err;

    varredura_tabela_if #(.N_IN(3)) bus2 ();
    varredura_tabela_if #(.N_IN(3)) bus1 ();

    assign bus2.start   = start;
    assign bus1.start   = start;
    assign bus2.dut_out = circ_tab[bus2.abc];
    assign bus1.dut_out = circ_tab[bus1.abc];

    varredura_tabela #(
        .N_IN     (3),
        .SETTLE   (2),
        .EXPECTED (TABELA_MUX)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    varredura_tabela #(
        .N_IN     (3),
        .SETTLE   (1),
        .EXPECTED (TABELA_MUX)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model: k = edges since the accepting edge (-1 = idle after reset). Each vector takes
    // s+1 cycles; vector i is captured once (i+1)*(s+1) edges have passed.
    int         k2 = -1;
    int         k1 = -1;
    logic [7:0] snap2 = 8'h00;
    logic [7:0] snap1 = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k2 <= -1;
            k1 <= -1;
        end else begin
            if ((k2 < 0 || k2 >= 24) && start) begin
                k2    <= 0;
                snap2 <= circ_tab;
            end else if (k2 >= 0 && k2 < 24) begin
                k2 <= k2 + 1;
            end
            if ((k1 < 0 || k1 >= 16) && start) begin
                k1    <= 0;
                snap1 <= circ_tab;
            end else if (k1 >= 0 && k1 < 16) begin
                k1 <= k1 + 1;
            end
        end
    end

    task automatic chk_dut(input string t, input int k, input int s, input logic [7:0] tab,
                           input logic [2:0] abc, input logic busy, input logic done,
                           input logic pass, input logic [7:0] tabela, input logic [3:0] erros);
        int         per;
        int         e_abc;
        int         e_busy;
        int         e_done;
        int         e_err;
        logic [7:0] m;
        per = s + 1;
        m   = 8'h00;
        if (k < 0) begin
            e_abc = 0; e_busy = 0; e_done = 0;
        end else if (k >= 8 * per) begin
            e_abc = 7; e_busy = 0; e_done = 1; m = 8'hFF;
        end else begin
            e_abc = k / per; e_busy = 1; e_done = 0;
            for (int i = 0; i < 8; i++) if ((i + 1) * per <= k) m[i] = 1'b1;
        end
        e_err = $countones((tab ^ TABELA_MUX) & m);
        chk({t, "_abc"},    int'(abc),    e_abc);
        chk({t, "_busy"},   int'(busy),   e_busy);
        chk({t, "_done"},   int'(done),   e_done);
        chk({t, "_tabela"}, int'(tabela), int'(tab & m));
        chk({t, "_erros"},  int'(erros),  e_err);
        if (e_done == 1) chk({t, "_pass"}, int'(pass), (e_err == 0) ? 1 : 0);
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk_dut("s2", k2, 2, snap2, bus2.abc, bus2.busy, bus2.done, bus2.pass,
                    bus2.tabela, bus2.erros);
            chk_dut("s1", k1, 1, snap1, bus1.abc, bus1.busy, bus1.done, bus1.pass,
                    bus1.tabela, bus1.erros);
        end
    end

    // One start pulse; n2/n1 = edge count (accepting edge = 1) at which done is first seen.
    // repulse: cycle at which start is pulsed again; rst_at: cycle at which reset is applied.
    task automatic sweep(input int repulse, input int rst_at, output int n2, output int n1);
        n2 = -1;
        n1 = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_done_low", int'(bus2.done), 0);
        chk("accept_tabela_clr", int'(bus2.tabela), 0);
        for (int c = 1; c <= 60; c++) begin
            if (bus2.done && n2 < 0) n2 = c;
            if (bus1.done && n1 < 0) n1 = c;
            if (n2 >= 0 && n1 >= 0) break;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_abc",    int'(bus2.abc),    0);
                chk("midrst_busy",   int'(bus2.busy),   0);
                chk("midrst_tabela", int'(bus2.tabela), 0);
                chk("midrst_done1",  int'(bus1.done),   0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (c == repulse) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    int         n2;
    int         n1;
    logic [7:0] rtab;

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        chk_en   = 1'b0;
        circ_tab = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_abc",    int'(bus2.abc),    0);
        chk("rst_tabela", int'(bus2.tabela), 0);
        chk("rst_erros",  int'(bus2.erros),  0);
        chk("rst_busy",   int'(bus2.busy),   0);
        chk("rst_done",   int'(bus2.done),   0);
        chk("rst_pass",   int'(bus2.pass),   0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Golden circuit ~(a^c).
        for (int i = 0; i < 8; i++) circ_tab[i] = ~(i[2] ^ i[0]);
        sweep(0, 0, n2, n1);
        chk("gold_done_cyc2", n2, 25);
        chk("gold_done_cyc1", n1, 17);
        chk("gold_tabela",    int'(bus2.tabela), 8'hA5);
        chk("gold_erros",     int'(bus2.erros),  0);
        chk("gold_pass",      int'(bus2.pass),   1);

        // Restart from DONE with stuck-at-0, plus an ignored start at cycle 10.
        circ_tab = 8'h00;
        sweep(10, 0, n2, n1);
        chk("stuck_done_cyc2", n2, 25);
        chk("stuck_done_cyc1", n1, 17);
        chk("stuck_tabela",    int'(bus2.tabela), 8'h00);
        chk("stuck_erros",     int'(bus2.erros),  4);
        chk("stuck_pass",      int'(bus2.pass),   0);
        chk("stuck_erros1",    int'(bus1.erros),  4);

        // Fully inverted circuit a^c.
        for (int i = 0; i < 8; i++) circ_tab[i] = i[2] ^ i[0];
        sweep(0, 0, n2, n1);
        chk("inv_tabela", int'(bus2.tabela), 8'h5A);
        chk("inv_erros",  int'(bus2.erros),  8);
        chk("inv_pass",   int'(bus2.pass),   0);

        // Reset at cycle 12 of a golden sweep, then a full clean sweep.
        circ_tab = 8'hA5;
        sweep(0, 12, n2, n1);
        repeat (2) @(negedge clk);
        sweep(0, 0, n2, n1);
        chk("postrst_done_cyc2", n2, 25);
        chk("postrst_tabela",    int'(bus2.tabela), 8'hA5);
        chk("postrst_pass",      int'(bus2.pass),   1);

        // Random circuits with random stray start pulses.
        for (int r = 0; r < 8; r++) begin
            rtab     = 8'($urandom);
            circ_tab = rtab;
            sweep(int'($urandom_range(2, 15)), 0, n2, n1);
            chk("rnd_done_cyc2", n2, 25);
            chk("rnd_done_cyc1", n1, 17);
            chk("rnd_tabela",    int'(bus2.tabela), int'(rtab));
            chk("rnd_erros",     int'(bus2.erros),  $countones(rtab ^ 8'hA5));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
